// File: rtl/step_pkg.sv
// Shared types and defaults for the two-channel step input conditioner.
package step_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'd0,
        CONFIRM_HIGH = 2'd1,
        IDLE_HIGH    = 2'd2,
        CONFIRM_LOW  = 2'd3
    } db_state_t;

    localparam int DB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchroniser, debounce FSM with run counter,
// registered debounced level and a one-cycle event on the selected commit edge.
module debounce_channel
    import step_pkg::*;
#(
    parameter int DB_CYCLES        = DB_CYCLES_DEFAULT,
    parameter int PULSE_ON_RELEASE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic lvl,
    output logic evt
);

    localparam int               CNT_W       = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic             EVT_ON_RISE = (PULSE_ON_RELEASE == 0);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             lvl_q,   lvl_d;
    logic             evt_q,   evt_d;

    // The counter holds how many consecutive opposite samples have been seen,
    // so a commit happens on the DB_CYCLES-th one.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        evt_d   = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (sync2_q) begin
                    state_d = CONFIRM_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CONFIRM_HIGH: begin
                if (!sync2_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    lvl_d   = 1'b1;
                    evt_d   = EVT_ON_RISE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync2_q) begin
                    state_d = CONFIRM_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CONFIRM_LOW: begin
                if (sync2_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    lvl_d   = 1'b0;
                    evt_d   = !EVT_ON_RISE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                lvl_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            evt_q   <= evt_d;
        end
    end

    assign lvl = lvl_q;
    assign evt = evt_q;

endmodule

// File: rtl/step_input_conditioner.sv
// Two debounced push-button channels feeding a registered priority arbiter that
// issues at most one step pulse per clock toward the step-ring FSM.
module step_input_conditioner
    import step_pkg::*;
#(
    parameter int DB_CYCLES        = DB_CYCLES_DEFAULT,
    parameter int PULSE_ON_RELEASE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic a1,
    output logic a2,
    output logic lvl1,
    output logic lvl2
);

    logic ch1_lvl, ch1_evt;
    logic ch2_lvl, ch2_evt;

    debounce_channel #(
        .DB_CYCLES        (DB_CYCLES),
        .PULSE_ON_RELEASE (PULSE_ON_RELEASE)
    ) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn1_raw),
        .lvl     (ch1_lvl),
        .evt     (ch1_evt)
    );

    debounce_channel #(
        .DB_CYCLES        (DB_CYCLES),
        .PULSE_ON_RELEASE (PULSE_ON_RELEASE)
    ) u_ch2 (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn2_raw),
        .lvl     (ch2_lvl),
        .evt     (ch2_evt)
    );

    logic pend1_q, pend1_d;
    logic pend2_q, pend2_d;
    logic a1_q,    a1_d;
    logic a2_q,    a2_d;
    logic lvl1_q,  lvl1_d;
    logic lvl2_q,  lvl2_d;
    logic req1,    req2;

    // Levels are re-registered here so lvl and the uncontended pulse change on the same edge.
    always_comb begin
        req1    = ch1_evt | pend1_q;
        req2    = ch2_evt | pend2_q;
        a1_d    = req1;
        a2_d    = req2 & ~req1;
        pend1_d = req1 & ~a1_d;
        pend2_d = req2 & ~a2_d;
        lvl1_d  = ch1_lvl;
        lvl2_d  = ch2_lvl;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            a1_q    <= 1'b0;
            a2_q    <= 1'b0;
            lvl1_q  <= 1'b0;
            lvl2_q  <= 1'b0;
        end else begin
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            lvl1_q  <= lvl1_d;
            lvl2_q  <= lvl2_d;
        end
    end

    assign a1   = a1_q;
    assign a2   = a2_q;
    assign lvl1 = lvl1_q;
    assign lvl2 = lvl2_q;

endmodule
